// File: rtl/keypad_pkg.sv
// Shared types and constants for the scanned 4x4 keypad input path.
package keypad_pkg;

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} kp_state_e;

  localparam int unsigned KEY_ROWS = 4;
  localparam int unsigned KEY_COLS = 4;
  localparam logic [KEY_ROWS-1:0] ROW_RESET = 4'b1110;

  // Index of the lowest low bit; returns 3 when only bit 3 (or none) is low.
  function automatic logic [1:0] low_index(input logic [3:0] v);
    if (!v[0]) return 2'd0;
    else if (!v[1]) return 2'd1;
    else if (!v[2]) return 2'd2;
    else return 2'd3;
  endfunction

endpackage

// File: rtl/scan_tick.sv
// Dwell counter: tick is high for one clock every SCAN_DELAY+1 clocks.
module scan_tick #(
  parameter int unsigned SCAN_DELAY = 100_000
) (
  input  logic clk_100M,
  input  logic rst,
  output logic tick
);

  localparam logic [16:0] LAST = 17'(SCAN_DELAY);

  logic [16:0] scan_cnt;

  assign tick = (scan_cnt == LAST);

  always_ff @(posedge clk_100M or posedge rst) begin
    if (rst) begin
      scan_cnt <= '0;
    end else if (tick) begin
      scan_cnt <= '0;
    end else begin
      scan_cnt <= scan_cnt + 17'd1;
    end
  end

endmodule

// File: rtl/keypad_scan_in.sv
// 4x4 keypad scanner with debounce; define KEYPAD_REPEAT_EN for auto-repeat while held.
module keypad_scan_in
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DELAY     = 100_000,
  parameter int unsigned DEBOUNCE_SCANS = 4,
  parameter int unsigned REPEAT_SCANS   = 200
) (
  input  logic                clk_100M,
  input  logic                rst,
  input  logic [KEY_COLS-1:0] kb_col,
  output logic [KEY_ROWS-1:0] kb_row,
  output logic [3:0]          key_code,
  output logic                key_valid,
  output logic                key_down
);

  localparam int unsigned CW = (DEBOUNCE_SCANS < 2) ? 1 : $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_SCANS);

  logic                tick;
  logic [KEY_COLS-1:0] col_s1, col_s2;
  logic                col_hit;
  logic [1:0]          col_sel;
  logic [1:0]          lat_col;
  logic [CW-1:0]       cnt, rcnt;
  kp_state_e           state;

  scan_tick #(
    .SCAN_DELAY(SCAN_DELAY)
  ) u_scan_tick (
    .clk_100M(clk_100M),
    .rst     (rst),
    .tick    (tick)
  );

  assign col_hit = ~&col_s2;
  assign col_sel = low_index(col_s2);

  always_ff @(posedge clk_100M or posedge rst) begin
    if (rst) begin
      col_s1 <= 4'hF;
      col_s2 <= 4'hF;
    end else begin
      col_s1 <= kb_col;
      col_s2 <= col_s1;
    end
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned RW = (REPEAT_SCANS < 2) ? 1 : $clog2(REPEAT_SCANS + 1);
  localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_SCANS);
  logic [RW-1:0] rpt;
`else
  // Auto-repeat is compiled out; the parameter only sizes it when enabled.
  if (REPEAT_SCANS == 0) begin : g_repeat_unused
  end
`endif

  always_ff @(posedge clk_100M or posedge rst) begin
    if (rst) begin
      state     <= SCAN;
      kb_row    <= ROW_RESET;
      lat_col   <= '0;
      cnt       <= '0;
      rcnt      <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_down  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rpt       <= '0;
`endif
    end else begin
      key_valid <= 1'b0;
      if (tick) begin
        unique case (state)
          SCAN: begin
            if (col_hit) begin
              lat_col <= col_sel;
              cnt     <= CW'(1);
              // A single-sample debounce accepts on the first hit.
              if (DB_LAST <= CW'(1)) begin
                key_code  <= {low_index(kb_row), col_sel};
                key_valid <= 1'b1;
                key_down  <= 1'b1;
                rcnt      <= '0;
                state     <= HELD;
`ifdef KEYPAD_REPEAT_EN
                rpt       <= '0;
`endif
              end else begin
                state <= DEBOUNCE;
              end
            end else begin
              kb_row <= {kb_row[KEY_ROWS-2:0], kb_row[KEY_ROWS-1]};
            end
          end
          DEBOUNCE: begin
            if (col_hit && col_sel == lat_col) begin
              if (cnt + CW'(1) == DB_LAST) begin
                key_code  <= {low_index(kb_row), lat_col};
                key_valid <= 1'b1;
                key_down  <= 1'b1;
                rcnt      <= '0;
                state     <= HELD;
`ifdef KEYPAD_REPEAT_EN
                rpt       <= '0;
`endif
              end
              cnt <= cnt + CW'(1);
            end else begin
              state  <= SCAN;
              kb_row <= {kb_row[KEY_ROWS-2:0], kb_row[KEY_ROWS-1]};
            end
          end
          HELD: begin
            if (col_hit) begin
              rcnt <= '0;
`ifdef KEYPAD_REPEAT_EN
              if (rpt + RW'(1) == RP_LAST) begin
                key_valid <= 1'b1;
                rpt       <= '0;
              end else begin
                rpt <= rpt + RW'(1);
              end
`endif
            end else if (rcnt + CW'(1) == DB_LAST) begin
              rcnt     <= '0;
              key_down <= 1'b0;
              state    <= SCAN;
              kb_row   <= {kb_row[KEY_ROWS-2:0], kb_row[KEY_ROWS-1]};
            end else begin
              rcnt <= rcnt + CW'(1);
            end
          end
          default: state <= SCAN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan_in.sv
// Directed bench for keypad_scan_in with SCAN_DELAY=3, DEBOUNCE_SCANS=3 (REPEAT_SCANS=2).
module tb_keypad_scan_in;

  logic        clk_100M = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  kb_col;
  logic [3:0]  kb_row;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_down;
  logic [15:0] keys = '0;

  int n_pass = 0;
  int n_chk  = 0;
  int pulses = 0;
  int b2b    = 0;
  bit prev_v = 1'b0;

  always #5 clk_100M = ~clk_100M;

  // Key matrix: a pressed key pulls its column low while its row is driven.
  always_comb begin
    kb_col = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (!kb_row[r] && keys[r*4+c]) kb_col[c] = 1'b0;
      end
    end
  end

  keypad_scan_in #(
    .SCAN_DELAY    (3),
    .DEBOUNCE_SCANS(3),
    .REPEAT_SCANS  (2)
  ) dut (
    .clk_100M (clk_100M),
    .rst      (rst),
    .kb_col   (kb_col),
    .kb_row   (kb_row),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_down (key_down)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk_100M);
    #1;
    if (key_valid === 1'b1) begin
      pulses++;
      if (prev_v) b2b++;
    end
    prev_v = (key_valid === 1'b1);
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic wait_row_change(output int n);
    logic [3:0] r0;
    r0 = kb_row;
    n = 0;
    do begin
      step();
      n++;
    end while (kb_row === r0 && n < 50);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (key_valid !== 1'b1 && n < 200);
  endtask

  task automatic wait_down_low(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (key_down !== 1'b0 && n < 200);
  endtask

  initial begin
    int n;
    int exp_pulses;
    logic [3:0] row_seq [4];
    row_seq[0] = 4'b1101;
    row_seq[1] = 4'b1011;
    row_seq[2] = 4'b0111;
    row_seq[3] = 4'b1110;
`ifdef KEYPAD_REPEAT_EN
    exp_pulses = 3;
`else
    exp_pulses = 1;
`endif

    // Reset and idle row rotation
    #1 rst = 1'b1;
    repeat (3) @(posedge clk_100M);
    #1;
    check("reset_row", kb_row, 4'b1110);
    check("reset_valid", key_valid, 1'b0);
    check("reset_code", key_code, 4'h0);
    check("reset_down", key_down, 1'b0);
    @(negedge clk_100M) rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wait_row_change(n);
      check("row_dwell", n, 4);
      check("row_seq", kb_row, row_seq[i]);
    end

    // Clean press of key 9 (row 2, col 1)
    pulses = 0;
    keys = 16'h0200;
    wait_valid(n);
    check("press_latency", n, 20);
    check("press_valid", key_valid, 1'b1);
    check("press_code", key_code, 4'h9);
    check("press_down", key_down, 1'b1);
    check("press_row", kb_row, 4'b1011);
    steps(16);
    check("held_row", kb_row, 4'b1011);
    check("held_down", key_down, 1'b1);
    check("held_pulses", pulses, exp_pulses);

    // Release: three high samples then the row advances
    keys = '0;
    wait_down_low(n);
    check("release_latency", n, 12);
    check("release_row", kb_row, 4'b0111);
    check("release_pulses", pulses, exp_pulses);

    // Bounce on key 12 (row 3, col 0) seen by one sample only
    pulses = 0;
    keys = 16'h1000;
    steps(4);
    check("bounce_row_held", kb_row, 4'b0111);
    keys = '0;
    steps(4);
    check("bounce_row_adv", kb_row, 4'b1110);
    steps(8);
    check("bounce_pulses", pulses, 0);
    check("bounce_code", key_code, 4'h9);
    check("bounce_down", key_down, 1'b0);

    // Two columns low in row 1: lowest column wins
    pulses = 0;
    keys = 16'h00A0;
    wait_valid(n);
    check("two_col_latency", n, 24);
    check("two_col_code", key_code, 4'h5);
    check("two_col_row", kb_row, 4'b1101);
    check("two_col_down", key_down, 1'b1);

    // Asynchronous reset while HELD
    steps(2);
    #2 rst = 1'b1;
    #1;
    check("midrst_down", key_down, 1'b0);
    check("midrst_row", kb_row, 4'b1110);
    check("midrst_code", key_code, 4'h0);
    check("midrst_valid", key_valid, 1'b0);
    keys = '0;
    @(negedge clk_100M) rst = 1'b0;
    pulses = 0;
    wait_row_change(n);
    check("midrst_dwell", n, 4);
    check("midrst_row_adv", kb_row, 4'b1101);
    steps(36);
    check("midrst_pulses", pulses, 0);
    check("midrst_down_after", key_down, 1'b0);

`ifdef KEYPAD_REPEAT_EN
    // Auto-repeat on key F every 2 ticks (8 clocks)
    keys = 16'h8000;
    wait_valid(n);
    check("rpt_first", key_valid, 1'b1);
    check("rpt_code0", key_code, 4'hF);
    wait_valid(n);
    check("rpt_gap1", n, 8);
    wait_valid(n);
    check("rpt_gap2", n, 8);
    check("rpt_code2", key_code, 4'hF);
    keys = '0;
    wait_down_low(n);
    check("rpt_release", key_down, 1'b0);
`endif

    check("no_back_to_back", b2b, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/keypad_scan_in.md
# keypad_scan_in

Scanned 4x4 key-matrix input adapter: the input-side counterpart of the multiplexed seven-segment display driver. It drives one keypad row low at a time with the same dwell-tick scheme the display scanner uses. It samples the active-low columns, debounces, and delivers a one-cycle `key_valid` pulse with a 4-bit key code. It sits between the board keypad pins and the experiment datapath, for example to load manual microprogram addresses or data.

## Interface
- `SCAN_DELAY`, default 100_000: row dwell. A scan tick fires every `SCAN_DELAY+1` clocks.
- `DEBOUNCE_SCANS`, default 4: consecutive matching samples needed to accept a press or a release.
- `REPEAT_SCANS`, default 200: scan ticks between auto-repeat pulses. Used only with `KEYPAD_REPEAT_EN`.
- `clk_100M`, in, 1: system clock. The block has one clock.
- `rst`, in, 1: reset, asynchronous and active-high.
- `kb_col`, in, 4: column sense lines, active-low, pulled up externally.
- `kb_row`, out, 4: row drive, one-hot active-low.
- `key_code`, out, 4: last accepted key, `row*4 + col`.
- `key_valid`, out, 1: one-cycle pulse when a key is accepted.
- `key_down`, out, 1: high while an accepted key is held.

## Operation
- **Column input path:** `kb_col` passes through a 2-flop synchronizer. Both flops reset to 4'hF.
- **Scan tick:** a 17-bit counter `scan_cnt` counts from 0 up to `SCAN_DELAY` and then wraps to 0. `scan_tick` is high on the cycle where `scan_cnt == SCAN_DELAY`. All sampling and all state changes happen only on `scan_tick` cycles.
- **Column selection:** `col_hit` is true when any synchronized column is low. When more than one column is low, the lowest-index column wins.
- **State SCAN**
  - On a tick with no `col_hit`: advance the row 0→1→2→3→0 by rotating `kb_row` left.
  - On a tick with `col_hit`: latch the row and column, set `cnt=1`, go to DEBOUNCE. The row stops rotating.
- **State DEBOUNCE**
  - On a tick where the same column is still low: `cnt++`.
  - When `cnt` reaches `DEBOUNCE_SCANS`: load `key_code`, pulse `key_valid`, go to HELD.
  - On a tick with no hit or a different column: go to SCAN and advance the row.
- **State HELD**
  - `key_down` is 1 and the row is held.
  - Each tick with all columns high increments `rcnt`; any tick with a column low clears `rcnt`.
  - When `rcnt` reaches `DEBOUNCE_SCANS`: go to SCAN and advance the row.
- **Registered outputs:** `key_down` is 1 exactly while in HELD. `key_code` keeps its value until the next accepted key.
- **Reset values:**
  - `kb_row = 4'b1110`
  - `key_code = 0`, `key_valid = 0`, `key_down = 0`
  - `scan_cnt = 0`, state = SCAN, all counters 0
- **Reset mid-operation:** reset at any time, including during DEBOUNCE or HELD, returns every register to its reset value immediately. No pulse is emitted.
- **Width rules:**
  - `cnt` and `rcnt` are wide enough for `DEBOUNCE_SCANS`.
  - `key_code` concatenates the 2-bit row index and the 2-bit column index.

## Timing
- A row is stable for `SCAN_DELAY+1` clocks before it is sampled. The synchronizer adds 2 cycles, which fits within the dwell.
- **Press latency:** `key_valid` goes high on the cycle after the tick that brings `cnt` to `DEBOUNCE_SCANS`. It is exactly 1 cycle wide.
  - With the key already synchronized at the first tick, the pulse arrives after `DEBOUNCE_SCANS-1` further ticks plus 1 cycle.
- **Release latency:** `key_down` falls on the cycle after the tick that brings `rcnt` to `DEBOUNCE_SCANS`. The row advances on that same edge.
- `key_valid` is never asserted in back-to-back cycles.

## Configuration
- **Macro `KEYPAD_REPEAT_EN` defined:**
  - In HELD, a repeat counter counts ticks while the key stays pressed.
  - Each time it reaches `REPEAT_SCANS`, `key_valid` pulses again with the unchanged `key_code`, and the counter clears.
  - The counter also clears on entry to HELD.
- **Macro undefined:** exactly one `key_valid` pulse per press. The repeat counter and the `REPEAT_SCANS` logic are absent.

## Structure
- **Package `keypad_pkg`:**
  - state enum `{SCAN, DEBOUNCE, HELD}`
  - `KEY_ROWS = 4`, `KEY_COLS = 4`
  - `ROW_RESET = 4'b1110`
- **Sub-module `scan_tick`:** the dwell counter, parameterized by `SCAN_DELAY`, with output `tick`. The display driver can reuse it.

## Test plan
All scenarios use `SCAN_DELAY=3` and `DEBOUNCE_SCANS=3`.
- **Reset:** assert `rst` with no keys pressed, then release it.
  - Expect `kb_row=1110` and all outputs 0.
  - Expect `kb_row` to step 1110→1101→1011→0111→1110, changing every 4 clocks.
- **Clean press:** hold col1 low whenever row2 is driven.
  - Expect a single `key_valid` pulse with `key_code=4'h9` and `key_down=1`, while `kb_row` stays at 1011.
  - Release the key: `key_down` falls after 3 high samples and the row advances to 0111.
- **Bounce:** col0 goes low for one sample only.
  - Expect DEBOUNCE then back to SCAN, no `key_valid`, and `key_code` unchanged.
- **Two columns:** in row 1, col1 and col3 are both low.
  - Expect `key_code=4'h5`.
- **Reset mid-HELD:** assert `rst` while in HELD.
  - Expect `key_down=0` and `kb_row=1110` asynchronously.
  - Expect no `key_valid` after reset is released.
- **Auto-repeat:** define `KEYPAD_REPEAT_EN`, set `REPEAT_SCANS=2`, hold key 4'hF.
  - Expect `key_valid` pulses at acceptance and then every 2 ticks.
